// File: rtl/serial_adder_nand_if.sv
// Handshake/result bundle for serial_adder_nand.
// SERIAL_ADDER_OVF_EN adds the signed-overflow flag.
interface serial_adder_nand_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
`endif
endinterface

// File: rtl/serial_adder_nand.sv
// Bit-serial LSB-first adder driving one NAND-only full adder cell.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output.
module full_adder_nand (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_co
);
  logic w_n1, w_n2, w_n3, w_x;
  logic w_n4, w_n5, w_n6;

  assign w_n1 = ~(i_a & i_b);
  assign w_n2 = ~(i_a & w_n1);
  assign w_n3 = ~(i_b & w_n1);
  assign w_x  = ~(w_n2 & w_n3);
  assign w_n4 = ~(w_x & i_c);
  assign w_n5 = ~(w_x & w_n4);
  assign w_n6 = ~(i_c & w_n4);
  assign o_s  = ~(w_n5 & w_n6);
  assign o_co = ~(w_n1 & w_n4);
endmodule

module serial_adder_nand #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_adder_nand_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int RW = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic [RW-1:0]    r_rs;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             w_s;
  logic             w_co;
  logic             w_last;
  logic             w_load;
  logic [WIDTH-1:0] w_rs_next;

  full_adder_nand u_fa (
    .i_a  (r_ra[0]),
    .i_b  (r_rb[0]),
    .i_c  (r_c),
    .o_s  (w_s),
    .o_co (w_co)
  );

  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_rs_next = {w_s, r_rs};
  assign w_load    = bus.start &&
                     (r_state == S_IDLE ||
                      r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_RUN;
      end
      S_RUN: begin
        bus.busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        w_next   = bus.start ? S_RUN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ra   <= '0;
      r_rb   <= '0;
      r_rs   <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_load) begin
      r_ra  <= bus.a;
      r_rb  <= bus.b;
      r_c   <= bus.cin;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_ra <= r_ra >> 1;
      r_rb <= r_rb >> 1;
      r_rs <= RW'(w_rs_next >> 1);
      r_c  <= w_co;
      if (w_last) begin
        r_cnt  <= '0;
        r_sum  <= w_rs_next;
        r_cout <= w_co;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // r_c is the carry into the MSB during the last RUN cycle
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_ovf <= 1'b0;
    else if (!w_load && r_state == S_RUN && w_last)
      r_ovf <= r_c ^ w_co;
  end

  assign bus.ovf = r_ovf;
`endif
endmodule

// File: doc/serial_adder_nand.md
# serial_adder_nand

Bit-serial, LSB-first adder that produces a WIDTH-bit sum plus carry-out by driving one `full_adder_nand` instance for WIDTH clock cycles, with a registered carry between bit steps. It sits directly upstream of the NAND full-adder cell: it owns the sequencing, operand shifting and carry storage, and the cell provides the per-bit sum and carry. It is the first clocked arithmetic block built on the NAND-only adder primitives and trades latency for a single adder cell.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 2..32.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  synchronous, active-low reset; one clock, sampled on the rising edge of `clk`.
- `start`  input  1  request to begin an addition; sampled only in IDLE or DONE.
- `a`  input  WIDTH  operand A; captured on the accepted `start` edge.
- `b`  input  WIDTH  operand B; captured on the accepted `start` edge.
- `cin`  input  1  carry-in; captured on the accepted `start` edge.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse; `sum` and `cout` are valid from this cycle onward.
- `sum`  output  WIDTH  registered result.
- `cout`  output  1  registered carry-out.
- `ovf`  output  1  signed overflow; present only when `SERIAL_ADDER_OVF_EN` is defined.

## Operation
- FSM states: IDLE, RUN and DONE; 2-bit state register.
- **IDLE:** if `start`=1, load shift registers `ra`<=`a` and `rb`<=`b`, set carry register `c`<=`cin` and bit counter `cnt`<=0, then go to RUN. Otherwise stay in IDLE.
- **RUN:** the full adder inputs are `ra[0]`, `rb[0]` and `c`. On each edge:
  - shift `ra` and `rb` right by one;
  - shift the adder sum bit into the MSB of result shift register `rs`;
  - `c`<=adder carry out;
  - `cnt`<=`cnt`+1.
- **Leaving RUN:** on the edge where `cnt`==WIDTH-1, write the final bit and set `sum`<={S, `rs`[WIDTH-1:1]} and `cout`<=adder carry out, then go to DONE.
- **DONE:** `done`=1 for exactly one cycle.
  - If `start`=1, reload exactly as in IDLE and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- `start` is ignored while in RUN; the operation in flight is unaffected.
- `sum` and `cout` change only on the edge that enters DONE, and hold through IDLE and through the next RUN until the next completion.
- `cnt` width is $clog2(WIDTH), with a minimum of 1 bit. `cnt` never exceeds WIDTH-1.
- The result is (a + b + cin) mod 2^WIDTH, with `cout` as bit WIDTH of the full sum.

## Timing
- Reset (`rst_n`=0 at an edge): state=IDLE; `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0; all internal registers cleared.
- Reset has priority over `start` and over every state, including mid-RUN. The partial result is discarded and `sum`/`cout` read 0.
- Latency: for `start` accepted at edge k, `busy`=1 in the cycles after edges k..k+WIDTH-1.
- At edge k+WIDTH the block enters DONE: `done`=1, and `sum`/`cout` become valid in the cycle after edge k+WIDTH.
- Throughput: one addition per WIDTH+1 cycles when `start` is held high.
- `busy` and `done` are never high in the same cycle.

## Configuration
- `SERIAL_ADDER_OVF_EN` defined:
  - adds port `ovf`;
  - on the edge that enters DONE, `ovf`<= (carry into the MSB) XOR (carry out of the MSB), with the carry into the MSB taken from `c` during the last RUN cycle;
  - `ovf` holds with the same rules as `sum`.
- `SERIAL_ADDER_OVF_EN` undefined: no `ovf` port and no extra register; all other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
- `a`=0x5A, `b`=0x3C, `cin`=0, pulse `start` -> `busy` for 8 cycles, then `done` pulse with `sum`=0x96, `cout`=0.
- `a`=0xFF, `b`=0x01, `cin`=0 -> `sum`=0x00, `cout`=1. Then `a`=0xFF, `b`=0xFF, `cin`=1 -> `sum`=0xFF, `cout`=1.
- `start` held high for 30 cycles with constant operands 0x01+0x02 -> `done` pulses every 9 cycles, each with `sum`=0x03, and `busy` never overlaps `done`.
- Start 0x10+0x20, then pulse `start` with `a`=0xAA in the third RUN cycle -> the second `start` is ignored and the result is `sum`=0x30, `cout`=0.
- Drive `rst_n`=0 for one edge in the fourth RUN cycle -> the next cycle shows `busy`=0, `sum`=0, `cout`=0, and no `done` ever follows.
- With `SERIAL_ADDER_OVF_EN` defined: 0x7F+0x01 -> `sum`=0x80, `ovf`=1; 0x80+0x80 -> `sum`=0x00, `cout`=1, `ovf`=1; 0x10+0x10 -> `ovf`=0.
